// File: rtl/word_asm_pkg.sv
// rtl/word_asm_pkg.sv - shared types and defaults for the byte-to-word assembler
package word_asm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int DEF_DIN_W = 8;
  localparam int DEF_RATIO = 4;

  function automatic int units_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs RATIO DIN_W-bit units into one word over valid/ready
// Define WORD_ASSEMBLER_LAST_EN to let DIN_LAST close a word early (zero-padded upper slots).
module word_assembler
  import word_asm_pkg::*;
#(
  parameter int DIN_W = DEF_DIN_W,
  parameter int RATIO = DEF_RATIO,
  localparam int UW   = units_w(RATIO)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DIN_W-1:0]       DATA_IN,
  input  logic                   DIN_VALID,
  output logic                   DIN_READY,
  input  logic                   DIN_LAST,
  output logic [DIN_W*RATIO-1:0] DATA_OUT,
  output logic                   DOUT_VALID,
  input  logic                   DOUT_READY,
  output logic [UW-1:0]          DOUT_UNITS,
  output logic                   BUSY
);

  localparam int W  = DIN_W * RATIO;
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   data_q;
  logic [UW-1:0]  units_q;
  logic           valid_q;

  logic           last_slot;
  logic           close_unit;
  logic           accept;
  logic           close;
  logic [W-1:0]   word_d;

  assign last_slot = (cnt_q == LAST_CNT);

`ifdef WORD_ASSEMBLER_LAST_EN
  // Any unit may close a word, so a pending unread word blocks every unit.
  assign close_unit = last_slot | DIN_LAST;
  assign DIN_READY  = !(valid_q & !DOUT_READY);
`else
  logic unused_din_last;
  assign unused_din_last = DIN_LAST;
  assign close_unit = last_slot;
  assign DIN_READY  = !(last_slot & valid_q & !DOUT_READY);
`endif

  assign accept = DIN_VALID & DIN_READY;
  assign close  = accept & close_unit;

  // Slots above cnt_q are still zero in acc_q, which gives the padding on early close.
  always_comb begin
    word_d = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) word_d[i*DIN_W +: DIN_W] = DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      units_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (close) begin
        data_q  <= word_d;
        units_q <= UW'(cnt_q) + UW'(1);
        valid_q <= 1'b1;
        cnt_q   <= '0;
        acc_q   <= '0;
        state_q <= IDLE;
      end else begin
        if (accept) begin
          acc_q   <= word_d;
          cnt_q   <= cnt_q + CW'(1);
          state_q <= FILL;
        end
        if (valid_q && DOUT_READY) valid_q <= 1'b0;
      end
    end
  end

  assign DATA_OUT   = data_q;
  assign DOUT_UNITS = units_q;
  assign DOUT_VALID = valid_q;
  assign BUSY       = (state_q == FILL) | valid_q;

endmodule

// File: doc/word_assembler.md
# word_assembler

Byte-to-word assembler: accepts a stream of DIN_W-bit units over a valid/ready handshake and packs RATIO consecutive units into one DIN_W*RATIO-bit word, presented on an output valid/ready port. It is the producer end of the word interface consumed by the team's word-splitting datapath (32-bit DATA_IN in, narrow slices out, BUSY status). With defaults it turns a byte stream into the 32-bit words that datapath expects. Full throughput: one unit per cycle sustained when the downstream keeps DOUT_READY high.

## Interface
- DIN_W, default 8: width of one input unit.
- RATIO, default 4: units per output word; legal range 2..16.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- DATA_IN  input  DIN_W  input unit.
- DIN_VALID  input  1  DATA_IN valid.
- DIN_READY  output  1  unit accepted when DIN_VALID & DIN_READY.
- DIN_LAST  input  1  accepted unit closes the current word early (see Configuration).
- DATA_OUT  output  DIN_W*RATIO  assembled word; unit 0 in bits [DIN_W-1:0].
- DOUT_VALID  output  1  DATA_OUT holds a word.
- DOUT_READY  input  1  downstream takes word when DOUT_VALID & DOUT_READY.
- DOUT_UNITS  output  $clog2(RATIO+1)  number of real units in DATA_OUT (1..RATIO).
- BUSY  output  1  partial word held or output word pending.

## Operation
- Registers: accumulator acc, unit counter cnt (0..RATIO-1), output register DATA_OUT/DOUT_UNITS, DOUT_VALID flag.
- FSM states: IDLE (cnt==0, no partial word), FILL (0<cnt<RATIO).
- IDLE -> FILL on accept without close; FILL -> IDLE on accept of unit RATIO-1 or (with LAST_EN) accept with DIN_LAST; word stays in FILL otherwise.
- Accepted unit written to acc slot cnt; cnt increments.
- Close event (cnt==RATIO-1, or DIN_LAST when enabled): {incoming unit, acc} loaded to DATA_OUT in one step; slots above the closing unit are zero; DOUT_UNITS = cnt+1; cnt -> 0; acc cleared.
- DIN_READY = !(closing_unit_possible & DOUT_VALID & !DOUT_READY): only a close may stall; non-closing units are always accepted. With LAST_EN, any unit may close, so DIN_READY = !(DOUT_VALID & !DOUT_READY) in every state.
- DOUT_VALID set on close, cleared on DOUT_READY handshake with no simultaneous close; close and handshake in the same cycle keep DOUT_VALID=1 with the new word.
- DATA_OUT/DOUT_UNITS stable while DOUT_VALID & !DOUT_READY.
- BUSY = (state==FILL) | DOUT_VALID.
- DIN_VALID with DIN_READY=0: unit not consumed, no state change; source must hold it.

## Timing
- Reset values: DOUT_VALID 0, DATA_OUT 0, DOUT_UNITS 0, BUSY 0, cnt 0, state IDLE; DIN_READY 1 in reset state.
- Latency: word visible on DATA_OUT with DOUT_VALID=1 the cycle after its closing unit is accepted.
- DIN_READY is combinational from state and DOUT_READY; no combinational path from DIN_VALID to any output.
- Throughput: RATIO accepted units -> one word; back-to-back words without bubbles when DOUT_READY=1.
- Reset mid-word or with pending output: partial and pending words discarded immediately (async), no spurious DOUT_VALID after release.

## Configuration
- WORD_ASSEMBLER_LAST_EN defined: DIN_LAST honoured; short words emitted with zero-padded upper slots and DOUT_UNITS < RATIO.
- Not defined: DIN_LAST ignored, words close only at RATIO units, DOUT_UNITS constant RATIO after first word (0 from reset), DIN_READY uses the narrow stall rule.

## Structure
- Package word_asm_pkg: state enum (IDLE, FILL), default DIN_W/RATIO constants, unit-count width function.
- No sub-module; single flat module (FSM, accumulator, output register).

## Test plan
- Send 0x11,0x22,0x33,0x44 with DOUT_READY=1 -> DATA_OUT=0x44332211, DOUT_UNITS=4, DOUT_VALID one cycle after 0x44 accepted.
- Stream 0x00..0x0B continuously, DOUT_READY=1 -> words 0x03020100, 0x07060504, 0x0B0A0908, DIN_READY never low.
- DOUT_READY=0 after first word, keep sending -> 3 further units accepted, 4th stalls (DIN_READY=0), DATA_OUT held at first word; release READY -> second word follows next cycle.
- LAST_EN: 0xAA, 0xBB with DIN_LAST on 0xBB -> DATA_OUT=0x0000BBAA, DOUT_UNITS=2; without macro same stimulus -> no output until 4 units.
- Assert RST after 2 units and with a word pending -> DOUT_VALID=0, BUSY=0 immediately; next 4 units form a fresh word, no stale bytes.
- Close coincident with DOUT handshake -> DOUT_VALID stays 1, new word replaces old, no cycle lost.
